instr_executor: RTL and testbench
=================================

Name: instr_executor

Overview:
- Reader/consumer side of the instruction register.
- After a start command, walks a window of register entries by driving read_index, captures each instruction_t, executes it, and presents one result per instruction on a valid/ready output channel.
- Sits between instr_register and any downstream result sink or scoreboard; it is the consumer that drains what the loader wrote.

Parameters:
- DEPTH, 32, number of instruction register entries; ADDR_W = $clog2(DEPTH).
- RESULT_W, 64, width of the signed result.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset_en  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- first_index  in  ADDR_W  first entry to read; sampled with start.
- count  in  ADDR_W+1  number of entries to execute, 0..DEPTH; sampled with start.
- read_index  out  ADDR_W  index driven to instr_register.
- instruction  in  instruction_t  {opcode, operand_a, operand_b}; combinational read of read_index.
- res_valid  out  1  result available.
- res_ready  in  1  sink accepts the result.
- res_data  out  RESULT_W  signed result.
- res_opcode  out  opcode_t  opcode that produced res_data.
- res_index  out  ADDR_W  entry index that produced res_data.
- res_div0  out  1  DIV/MOD with operand_b == 0.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE; read_index = 0; all res_* = 0; busy = 0; done = 0; internal counters = 0.
  - A reset in mid-run abandons the run; no further results are produced.
- States: IDLE, FETCH, EXEC, RESP, DONE.
- IDLE: start=1 -> latch first_index into read_index, latch count into remaining.
  - count == 0 -> go to DONE.
  - Otherwise -> go to FETCH.
  - start is ignored in all other states.
- FETCH: one cycle in which instruction settles for read_index. At the edge, capture instruction and read_index into internal registers; -> EXEC.
- EXEC: compute from the captured copy; at the edge load res_data, res_opcode, res_index, res_div0, set res_valid=1; -> RESP.
- RESP: res_* are held stable while res_valid && !res_ready. On res_valid && res_ready:
  - clear res_valid;
  - decrement remaining;
  - if remaining was 1 -> DONE;
  - else read_index <= (read_index+1) mod DEPTH (wraps DEPTH-1 -> 0) -> FETCH.
- DONE: done=1 for exactly one cycle -> IDLE. busy=0 in the same cycle that IDLE is entered.
- Latency and throughput:
  - Start edge to res_valid high: 2 edges.
  - Throughput: 1 result per 3 cycles with res_ready held high.
- Arithmetic: operands are sign-extended to RESULT_W.
  - ZERO: 0.
  - PASSA: a.
  - PASSB: b.
  - ADD: a+b.
  - SUB: a-b.
  - MULT: full signed product.
  - DIV: a/b, truncated toward zero.
  - MOD: a%b, sign follows a.
  - DIV or MOD with b == 0: res_data = 0 and res_div0 = 1; otherwise res_div0 = 0.
  - An opcode outside the enum gives res_data = 0.
- Entries are read exactly once per run in wrap order. The block does not drive load_en or write_index; writer/reader coherence is the system's responsibility.

Decomposition:
- instr_register_pkg additions: result_t (signed [RESULT_W-1:0]), exec_state_t enum.
- Reuse existing opcode_t, operand_t, address_t, instruction_t.
- One sub-module, instr_alu: purely combinational (instruction_t in -> result_t, div0 out), instantiated in EXEC.

Test Plan:
- Reset asserted mid-run (during RESP with res_valid=1) -> all outputs 0 asynchronously, state IDLE; a following start runs cleanly.
- Load entries 0..7 with ADD, SUB, MULT, DIV, MOD, PASSA, PASSB, ZERO, all with a=7, b=3; start first_index=0 count=8, res_ready=1. Required results in order: 10, 4, 21, 2, 1, 7, 3, 0. res_index 0..7, done pulses once after the 8th result.
- Signed cases:
  - DIV a=-7 b=2 -> -3.
  - MOD a=-7 b=2 -> -1.
  - MULT a=32'h7FFFFFFF b=2 -> 64'h00000000FFFFFFFE.
  - SUB a=1 b=5 -> -4.
- DIV a=9 b=0 -> res_data=0, res_div0=1; the next entry ADD 1,1 -> 2, res_div0=0.
- Backpressure: hold res_ready=0 for 5 cycles while res_valid=1 -> res_* stay stable; on the first res_ready=1 exactly one result is consumed.
- Wrap and edge counts:
  - first_index=30 count=4 -> read_index sequence 30, 31, 0, 1.
  - count=0 -> done pulses 1 cycle after start, res_valid never rises.
  - start asserted while busy -> ignored.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its executor: opcodes,
// operands, the stored instruction word, the signed result and executor states.
package instr_register_pkg;

  localparam int REG_DEPTH  = 32;
  localparam int REG_ADDR_W = $clog2(REG_DEPTH);
  localparam int OPERAND_W  = 32;
  localparam int RES_W      = 64;

  // Four bits wide so that codes beyond MOD can exist and are treated as illegal.
  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [OPERAND_W-1:0] operand_t;
  typedef logic [REG_ADDR_W-1:0]       address_t;

  typedef struct packed {
    opcode_t  opcode;
    operand_t operand_a;
    operand_t operand_b;
  } instruction_t;

  typedef logic signed [RES_W-1:0] result_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    RESP,
    DONE
  } exec_state_t;

  // Sign-extend an operand to the full result width.
  function automatic result_t sext(input operand_t v);
    return {{(RES_W-OPERAND_W){v[OPERAND_W-1]}}, v};
  endfunction

endpackage

// File: rtl/instr_alu.sv
// Combinational arithmetic unit: evaluates one captured instruction into a
// signed result, flagging division or modulo by zero.
module instr_alu
  import instr_register_pkg::*;
(
  input  instruction_t instr,
  output result_t      result,
  output logic         div0
);

  result_t a;
  result_t b;

  assign a = sext(instr.operand_a);
  assign b = sext(instr.operand_b);

  // Decode the opcode; illegal codes and zero divisors produce a zero result.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    result = '0;
    div0   = 1'b0;
    case (instr.opcode)
      ZERO:  result = '0;
      PASSA: result = a;
      PASSB: result = b;
      ADD:   result = a + b;
      SUB:   result = a - b;
      MULT:  result = a * b;
      DIV: begin
        if (b == '0) div0 = 1'b1;
        else         result = a / b;
      end
      MOD: begin
        if (b == '0) div0 = 1'b1;
        else         result = a % b;
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/instr_executor.sv
// Consumer side of the instruction register: walks a window of entries,
// executes each one and offers one result per entry on a valid/ready channel.
module instr_executor
  import instr_register_pkg::*;
#(
  parameter  int DEPTH    = 32,
  parameter  int RESULT_W = 64,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset_en,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          first_index,
  input  logic [ADDR_W:0]            count,
  output logic [ADDR_W-1:0]          read_index,
  input  instruction_t               instruction,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic signed [RESULT_W-1:0] res_data,
  output opcode_t                    res_opcode,
  output logic [ADDR_W-1:0]          res_index,
  output logic                       res_div0,
  output logic                       busy,
  output logic                       done
);

  exec_state_t       state;
  exec_state_t       next_state;
  logic [ADDR_W:0]   remaining;
  instruction_t      cap_instr;
  logic [ADDR_W-1:0] cap_index;
  logic [ADDR_W-1:0] next_index;
  result_t           alu_result;
  logic              alu_div0;
  logic              accept;
  logic              last_entry;

  assign accept     = res_valid && res_ready;
  assign last_entry = (remaining == (ADDR_W+1)'(1));
  assign next_index = (read_index == ADDR_W'(DEPTH-1)) ? '0 : read_index + 1'b1;

  instr_alu u_alu (
    .instr  (cap_instr),
    .result (alu_result),
    .div0   (alu_div0)
  );

  // State register; reset abandons any run in progress.
  always_ff @(posedge clk or posedge reset_en) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    if (reset_en) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state decode plus the status outputs derived from the state.
  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE:    if (start) next_state = (count == '0) ? DONE : FETCH;
      FETCH:   next_state = EXEC;
      EXEC:    next_state = RESP;
      RESP:    if (accept) next_state = last_entry ? DONE : FETCH;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Run bookkeeping, instruction capture and the held result registers.
  always_ff @(posedge clk or posedge reset_en) begin
    if (reset_en) begin
      read_index <= '0;
      remaining  <= '0;
      cap_instr  <= '0;
      cap_index  <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_opcode <= ZERO;
      res_index  <= '0;
      res_div0   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            read_index <= first_index;
            remaining  <= count;
          end
        end
        FETCH: begin
          cap_instr <= instruction;
          cap_index <= read_index;
        end
        EXEC: begin
          res_data   <= RESULT_W'(alu_result);
          res_opcode <= cap_instr.opcode;
          res_index  <= cap_index;
          res_div0   <= alu_div0;
          res_valid  <= 1'b1;
        end
        RESP: begin
          if (accept) begin
            res_valid <= 1'b0;
            remaining <= remaining - 1'b1;
            if (!last_entry) read_index <= next_index;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_executor.sv
// Self-checking bench for instr_executor: a behavioural register-file model
// feeds instructions, directed tables and random runs are scored per result.
module tb_instr_executor;
  import instr_register_pkg::*;

  logic               clk;
  logic               reset_en;
  logic               start;
  logic [4:0]         first_index;
  logic [5:0]         count;
  logic [4:0]         read_index;
  instruction_t       instruction;
  logic               res_valid;
  logic               res_ready;
  logic signed [63:0] res_data;
  opcode_t            res_opcode;
  logic [4:0]         res_index;
  logic               res_div0;
  logic               busy;
  logic               done;

  instruction_t mem [32];
  longint       exp_data [32];
  bit           exp_d0 [32];

  int tests = 0;
  int fails = 0;

  typedef struct {
    opcode_t op;
    int      a;
    int      b;
    longint  exp;
    bit      d0;
  } vec_t;

  vec_t vecs [14];

  assign instruction = mem[read_index];

  instr_executor #(.DEPTH(32), .RESULT_W(64)) dut (
    .clk         (clk),
    .reset_en    (reset_en),
    .start       (start),
    .first_index (first_index),
    .count       (count),
    .read_index  (read_index),
    .instruction (instruction),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_opcode  (res_opcode),
    .res_index   (res_index),
    .res_div0    (res_div0),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Reference arithmetic straight from the opcode definitions, in 64-bit integers.
  function automatic longint model(input opcode_t op, input int a, input int b, output bit d0);
    longint la;
    longint lb;
    la = a;
    lb = b;
    d0 = 1'b0;
    case (op)
      ZERO:  return 0;
      PASSA: return la;
      PASSB: return lb;
      ADD:   return la + lb;
      SUB:   return la - lb;
      MULT:  return la * lb;
      DIV:   begin if (b == 0) begin d0 = 1'b1; return 0; end return la / lb; end
      MOD:   begin if (b == 0) begin d0 = 1'b1; return 0; end return la % lb; end
      default: return 0;
    endcase
  endfunction

  task automatic fill_exp;
    bit d;
    for (int i = 0; i < 32; i++) begin
      exp_data[i] = model(mem[i].opcode, mem[i].operand_a, mem[i].operand_b, d);
      exp_d0[i]   = d;
    end
  endtask

  task automatic randomize_mem;
    int sel;
    for (int i = 0; i < 32; i++) begin
      mem[i].opcode    = opcode_t'(4'($urandom_range(0, 9)));
      mem[i].operand_a = $urandom;
      sel = $urandom_range(0, 3);
      if (sel == 0)      mem[i].operand_b = 0;
      else if (sel == 1) mem[i].operand_b = $urandom_range(0, 20) - 10;
      else               mem[i].operand_b = $urandom;
    end
    fill_exp();
  endtask

  task automatic wait_valid(input string name);
    int c = 0;
    while (!res_valid && c < 20) begin
      tick();
      c++;
    end
    check(name, res_valid, 1'b1);
  endtask

  // Start a run at a negedge and consume every result, scoring each against
  // exp_data/exp_d0/mem. noisy keeps start high with other values while busy.
  task automatic run(input int first, input int cnt, input int ready_pct, input bit noisy);
    int n   = 0;
    int cyc = 0;
    int idx;
    start       = 1'b1;
    first_index = 5'(first);
    count       = 6'(cnt);
    tick();
    if (noisy) begin
      first_index = 5'(first + 7);
      count       = 6'd3;
    end else begin
      start = 1'b0;
    end
    while (n < cnt && cyc < 40 * cnt + 20) begin
      res_ready = ($urandom_range(0, 99) < ready_pct);
      if (res_valid && res_ready) begin
        idx = (first + n) % 32;
        check("res_data", res_data, exp_data[idx]);
        check("res_div0", res_div0, exp_d0[idx]);
        check("res_index", res_index, idx);
        check("res_opcode", res_opcode, mem[idx].opcode);
        n++;
        if (n == cnt) start = 1'b0;
      end
      tick();
      cyc++;
    end
    res_ready = 1'b0;
    start     = 1'b0;
    check("result_count", n, cnt);
    if (ready_pct >= 100) check("throughput_cycles", cyc, 3 * cnt);
    check("done_pulse", done, 1'b1);
    check("done_res_valid", res_valid, 1'b0);
    tick();
    check("done_low", done, 1'b0);
    check("idle_busy", busy, 1'b0);
  endtask

  initial begin
    logic [63:0] s_data;
    logic [4:0]  s_index;
    logic [3:0]  s_op;
    logic        s_d0;

    reset_en    = 1'b1;
    start       = 1'b0;
    res_ready   = 1'b0;
    first_index = '0;
    count       = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;

    // Reset state
    #2;
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_read_index", read_index, 5'd0);
    check("rst_res_data", res_data, 64'd0);
    tick();
    tick();
    reset_en = 1'b0;
    tick();

    // Directed vector table
    vecs[0]  = '{ADD,   7,  3, 10, 1'b0};
    vecs[1]  = '{SUB,   7,  3,  4, 1'b0};
    vecs[2]  = '{MULT,  7,  3, 21, 1'b0};
    vecs[3]  = '{DIV,   7,  3,  2, 1'b0};
    vecs[4]  = '{MOD,   7,  3,  1, 1'b0};
    vecs[5]  = '{PASSA, 7,  3,  7, 1'b0};
    vecs[6]  = '{PASSB, 7,  3,  3, 1'b0};
    vecs[7]  = '{ZERO,  7,  3,  0, 1'b0};
    vecs[8]  = '{DIV,  -7,  2, -3, 1'b0};
    vecs[9]  = '{MOD,  -7,  2, -1, 1'b0};
    vecs[10] = '{MULT, 32'h7FFFFFFF, 2, 64'h00000000FFFFFFFE, 1'b0};
    vecs[11] = '{SUB,   1,  5, -4, 1'b0};
    vecs[12] = '{DIV,   9,  0,  0, 1'b1};
    vecs[13] = '{ADD,   1,  1,  2, 1'b0};
    for (int i = 0; i < 14; i++) begin
      mem[i].opcode    = vecs[i].op;
      mem[i].operand_a = vecs[i].a;
      mem[i].operand_b = vecs[i].b;
      exp_data[i]      = vecs[i].exp;
      exp_d0[i]        = vecs[i].d0;
    end
    run(0, 8, 100, 1'b0);
    run(8, 6, 100, 1'b0);

    // Reset asserted mid-run while a result is waiting
    randomize_mem();
    mem[10] = '{ADD, 32'sd5, 32'sd6};
    fill_exp();
    start = 1'b1; first_index = 5'd10; count = 6'd3;
    tick();
    start = 1'b0;
    wait_valid("mid_reset_valid");
    reset_en = 1'b1;
    #1;
    check("mid_rst_res_valid", res_valid, 1'b0);
    check("mid_rst_res_data", res_data, 64'd0);
    check("mid_rst_res_index", res_index, 5'd0);
    check("mid_rst_res_opcode", res_opcode, 4'd0);
    check("mid_rst_read_index", read_index, 5'd0);
    check("mid_rst_busy", busy, 1'b0);
    tick();
    reset_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("post_rst_quiet", res_valid, 1'b0);
      tick();
    end
    run(10, 3, 100, 1'b0);

    // Backpressure and start-to-valid latency
    start = 1'b1; first_index = 5'd20; count = 6'd2;
    tick();
    start = 1'b0;
    check("lat_fetch_invalid", res_valid, 1'b0);
    tick();
    check("lat_exec_invalid", res_valid, 1'b0);
    tick();
    check("lat_valid", res_valid, 1'b1);
    s_data = res_data; s_index = res_index; s_op = res_opcode; s_d0 = res_div0;
    check("bp_data_exp", s_data, exp_data[20]);
    check("bp_index_exp", s_index, 5'd20);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid_held", res_valid, 1'b1);
      check("bp_data_held", res_data, s_data);
      check("bp_index_held", res_index, s_index);
      check("bp_op_held", res_opcode, s_op);
      check("bp_d0_held", res_div0, s_d0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp_one_consumed", res_valid, 1'b0);
    check("bp_still_busy", busy, 1'b1);
    wait_valid("bp_second_valid");
    check("bp_second_index", res_index, 5'd21);
    check("bp_second_data", res_data, exp_data[21]);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp_done", done, 1'b1);
    tick();

    // Wrap across the top of the register
    run(30, 4, 100, 1'b0);

    // count == 0: immediate done, no result
    start = 1'b1; first_index = 5'd3; count = 6'd0;
    tick();
    start = 1'b0;
    check("zero_done", done, 1'b1);
    check("zero_valid", res_valid, 1'b0);
    tick();
    check("zero_done_low", done, 1'b0);
    check("zero_idle", busy, 1'b0);
    check("zero_valid_after", res_valid, 1'b0);

    // start held high with other values while busy is ignored
    run(4, 2, 100, 1'b1);

    // Randomized runs against the reference model
    for (int r = 0; r < 6; r++) begin
      randomize_mem();
      run($urandom_range(0, 31), $urandom_range(1, 32), 60, r[0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
